// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA sync, blanking and active-pixel coordinate generator.
// Define VGA_PIXEL_DIV_EN to advance on every 2nd clk (e.g. 50 MHz clk -> 25 MHz pixel).
module vga_timing_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       hs_n,
    output logic       vs_n,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC - 1);
    localparam logic [9:0] H_BP_END   = 10'(H_SYNC + H_BP - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_ORG      = 10'(H_SYNC + H_BP);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC - 1);
    localparam logic [9:0] V_BP_END   = 10'(V_SYNC + V_BP - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_ORG      = 10'(V_SYNC + V_BP);

    typedef enum logic [1:0] {H_SYNC_S, H_BP_S, H_ACT_S, H_FP_S} h_state_t;
    typedef enum logic [1:0] {V_SYNC_S, V_BP_S, V_ACT_S, V_FP_S} v_state_t;

    logic [9:0] hcount, vcount, hcount_nx, vcount_nx;
    h_state_t   h_state, h_state_nx;
    v_state_t   v_state, v_state_nx;
    logic       tick, adv, h_wrap, v_wrap, line_adv, act_nx;

`ifdef VGA_PIXEL_DIV_EN
    logic phase;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) phase <= 1'b0;
        else        phase <= ~phase;
    assign tick = phase;
`else
    assign tick = 1'b1;
`endif

    assign adv      = tick & run;
    assign h_wrap   = hcount == H_LAST;
    assign v_wrap   = vcount == V_LAST;
    assign line_adv = adv & h_wrap;

    // Outputs are decoded from next-state values so they line up with the registered counters.
    always_comb begin
        hcount_nx  = adv ? (h_wrap ? 10'd0 : hcount + 10'd1) : hcount;
        vcount_nx  = line_adv ? (v_wrap ? 10'd0 : vcount + 10'd1) : vcount;
        h_state_nx = h_state;
        v_state_nx = v_state;
        if (adv)
            case (h_state)
                H_SYNC_S: if (hcount == H_SYNC_END) h_state_nx = H_BP_S;
                H_BP_S:   if (hcount == H_BP_END)   h_state_nx = H_ACT_S;
                H_ACT_S:  if (hcount == H_ACT_END)  h_state_nx = H_FP_S;
                H_FP_S:   if (h_wrap)               h_state_nx = H_SYNC_S;
            endcase
        if (line_adv)
            case (v_state)
                V_SYNC_S: if (vcount == V_SYNC_END) v_state_nx = V_BP_S;
                V_BP_S:   if (vcount == V_BP_END)   v_state_nx = V_ACT_S;
                V_ACT_S:  if (vcount == V_ACT_END)  v_state_nx = V_FP_S;
                V_FP_S:   if (v_wrap)               v_state_nx = V_SYNC_S;
            endcase
        act_nx = (h_state_nx == H_ACT_S) && (v_state_nx == V_ACT_S);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            h_state     <= H_SYNC_S;
            v_state     <= V_SYNC_S;
            hs_n        <= 1'b0;
            vs_n        <= 1'b0;
            video_on    <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= hcount_nx;
            vcount      <= vcount_nx;
            h_state     <= h_state_nx;
            v_state     <= v_state_nx;
            hs_n        <= h_state_nx != H_SYNC_S;
            vs_n        <= v_state_nx != V_SYNC_S;
            video_on    <= act_nx;
            x           <= act_nx ? hcount_nx - H_ORG : 10'd0;
            y           <= act_nx ? vcount_nx - V_ORG : 10'd0;
            line_start  <= line_adv;
            frame_start <= line_adv & v_wrap;
        end
    end
endmodule
